demux_sched: RTL

Scheduler that feeds a 1-to-N demultiplexer from a single valid/ready input stream. It holds one item at a time and picks the destination lane by round-robin over enabled lanes or by an explicit per-item address. It drives the demux select and enable, applies per-lane backpressure, and counts delivered and dropped items. It sits between the upstream producer and the N downstream lane consumers.

---
 rtl/demux_sched.sv | 111 +++++++++++
 1 files changed

// File: rtl/demux_sched.sv
// demux_sched: single-item holding scheduler in front of a 1-to-N demux.
// Picks the lane by round-robin over enabled lanes or by per-item address,
// applies per-lane backpressure and counts delivered/dropped items.
module demux_sched #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_dest,
  input  logic          mode,
  input  logic [N-1:0]  lane_mask,
  input  logic [N-1:0]  lane_ready,
  output logic [N-1:0]  out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_sel,
  output logic          busy,
  output logic [15:0]   sent_cnt,
  output logic [7:0]    drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  data_q,  data_d;
  logic [SW-1:0] sel_q,   sel_d;
  logic [SW-1:0] ptr_q,   ptr_d;
  logic [15:0]   sent_q,  sent_d;
  logic [7:0]    drop_q,  drop_d;

  logic          deliver, accept, load, drop, addr_ok, rr_found;
  logic [SW-1:0] rr_tgt, tgt;

  // Round-robin search: first enabled lane at or after ptr, wrapping at N-1.
  always_comb begin
    logic [SW:0] idx;
    rr_found = 1'b0;
    rr_tgt   = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (SW+1)'(i);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!rr_found && lane_mask[idx[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_tgt   = idx[SW-1:0];
      end
    end
  end

  // Handshake decode: delivery, acceptance, and whether an accepted item loads or drops.
  always_comb begin
    addr_ok  = ({1'b0, in_dest} < (SW+1)'(N)) && lane_mask[in_dest];
    deliver  = (state_q == HOLD) && lane_ready[sel_q];
    // Holding with a stalled lane blocks upstream; RR with no lane enabled has nowhere to go.
    in_ready = !rst && ((state_q == IDLE) || deliver) && (mode || (|lane_mask));
    accept   = in_valid && in_ready;
    load     = accept && (mode ? addr_ok : rr_found);
    drop     = accept && mode && !addr_ok;
    tgt      = mode ? in_dest : rr_tgt;
  end

  // Next-state: load wins over delivery so back-to-back items see no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    sent_d  = sent_q + {15'd0, deliver};
    drop_d  = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    if (load) begin
      state_d = HOLD;
      data_d  = in_data;
      sel_d   = tgt;
      if (!mode) ptr_d = (rr_tgt == SW'(N-1)) ? '0 : rr_tgt + 1'b1;
    end else if (deliver) begin
      state_d = IDLE;
    end
  end

  // State and counter registers; reset discards any held item without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = (state_q == HOLD) ? (N'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign busy      = (state_q == HOLD);
  assign sent_cnt  = sent_q;
  assign drop_cnt  = drop_q;

endmodule
